alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Two-requester front end for the 8-bit ALU.
- Accepts operation requests (opcode, a, b) from two clients over valid/ready, arbitrates round-robin and drives the ALU operand/select ports.
- Holds operands and select stable for the ALU's registered latency, captures the 16-bit result and carry, and returns them to the winning client over a per-client valid/ready response channel.
- Sits between the ALU and its two users (sequencer and debug port); one operation is in flight at a time.

## Interface
- ALU_LAT, 2, clock edges from ALU operand/select change to valid ALU result; legal range 2..15

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid
- req0_op / req1_op  in  4  ALU opcode (0..15)
- req0_a, req0_b / req1_a, req1_b  in  8  operands
- rsp0_valid / rsp1_valid  out  1  response for that client
- rsp0_ready / rsp1_ready  in  1  client takes response
- rsp_y  out  16  captured result (shared by both clients)
- rsp_carry  out  1  captured ALU carry
- rsp_zero  out  1  high when captured rsp_y == 0
- rsp_err  out  1  divide-by-zero rejection (see Configuration)
- alu_a, alu_b  out  8  ALU operands
- alu_s  out  4  ALU opcode select
- alu_en  out  1  ALU clear, active-high
- alu_y  in  16  ALU result
- alu_carry  in  1  ALU carry
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Ready goes only to the arbitration winner, combinationally.
  - Winner: the single valid requester; if both are valid, the requester not granted last.
  - last_grant resets to 1, so req0 wins the first tie.
  - On valid&&ready: latch op/a/b/client id, load counter = ALU_LAT, update last_grant, go to EXEC.
- **EXEC:**
  - alu_a/alu_b/alu_s are registered from the latch; they change only on accept and are otherwise held.
  - Counter decrements each cycle.
  - At the edge where counter == 0: capture alu_y → rsp_y and alu_carry → rsp_carry, compute rsp_zero from the captured value, rsp_err = 0, go to RESP.
- **RESP:**
  - rsp{id}_valid = 1; the other client's rsp valid = 0.
  - rsp_y/carry/zero/err held stable until rsp{id}_ready; then go to IDLE.
  - No new accept occurs in the handshake cycle.
- Both req_ready are 0 outside IDLE. rsp valids are 0 outside RESP.
- The ALU's own zero flag is not used; zero is always derived locally.

## Timing
- **Reset values:**
  - state = IDLE, last_grant = 1, all ready/valid = 0, busy = 0.
  - rsp_y = 0, rsp_carry = rsp_zero = rsp_err = 0.
  - alu_a = alu_b = alu_s = 0, alu_en = 1.
- alu_en is registered: 1 while rst_n is sampled low, 0 from the first edge with rst_n high.
- **Latency:**
  - Accept at edge T.
  - Capture at edge T+ALU_LAT+1.
  - rsp valid is high in the cycle after T+ALU_LAT+1.
- **Minimum throughput:** one operation per ALU_LAT+3 cycles with rsp_ready held high.
- **Simultaneous request valid and response handshake:** the request waits for IDLE.
- **Reset mid-EXEC or mid-RESP:**
  - The in-flight operation is discarded with no response, and last_grant returns to 1.
  - Held requests are re-arbitrated after reset.
- A requester may drop valid before ready without error; no state changes.

## Configuration
- **ALU_ARB_DIVZERO_EN defined:**
  - Accepting op == 5 with b == 0 skips EXEC: alu_* ports are not updated.
  - Next state is RESP at the accept edge, with rsp_y = 16'hFFFF, rsp_carry = 0, rsp_zero = 0, rsp_err = 1.
- **Undefined:**
  - op 5 with b == 0 is issued to the ALU like any other op.
  - rsp_err is constant 0.

## Test plan
- **Single add:** req0 op=0, a=8'h0F, b=8'h01, rsp0_ready=1 → rsp0_valid first high 3 cycles after accept edge (ALU_LAT=2), rsp_y=16'h0010, rsp_carry=0, rsp_zero=0, rsp1_valid stays 0.
- **Tie after reset:** req0 op=6, a=F0, b=0F and req1 op=8, a=AA, b=55 both valid → req0 served first, rsp_y=0000, rsp_zero=1; then req1, rsp_y=00FF; with both held valid, grants alternate 0,1,0,1.
- **Backpressure:** req1 op=7 a=12 b=21, rsp1_ready low 5 cycles → rsp1_valid and rsp_y=0033 stable, req0_ready/req1_ready = 0, busy = 1; ready high → IDLE next cycle.
- **Reset mid-EXEC:** assert rst_n=0 for one edge one cycle after accept → no rsp valid ever for that op, alu_en=1 for that cycle, all outputs at reset values; next tie grants req0.
- **Divide by zero:** op=5 a=09 b=00.
  - With ALU_ARB_DIVZERO_EN: rsp valid the cycle after accept, rsp_y=FFFF, rsp_err=1, alu_s unchanged.
  - Without: normal 3-cycle latency, rsp_err=0.
- **Starvation:** req0 valid continuously with new ops, req1 raised mid-transaction → req1 granted at the next IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-client front end for a registered-latency 8-bit ALU.
// Optional feature: define ALU_ARB_DIVZERO_EN to reject op 5 with b == 0 without issuing it.
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_y,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_en,
  input  logic [15:0] alu_y,
  input  logic        alu_carry,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state;
  logic        last_grant;
  logic        id;
  logic [3:0]  cnt;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        div_zero;
  logic        rsp_done;
  logic [3:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  // Round-robin winner selection; ready is offered only to the winner and only in IDLE
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    op         = grant1 ? req1_op : req0_op;
    a          = grant1 ? req1_a : req0_a;
    b          = grant1 ? req1_b : req0_b;
    rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    busy       = state != IDLE;
  end
`ifdef ALU_ARB_DIVZERO_EN
  assign div_zero = (op == 4'd5) && (b == 8'd0);
  // Error flag raised by a rejected divide, cleared by any normal capture
  always_ff @(posedge clk) begin
    if (!rst_n) rsp_err <= 1'b0;
    else if (state == IDLE && accept && div_zero) rsp_err <= 1'b1;
    else if (state == EXEC && cnt == 4'd0) rsp_err <= 1'b0;
  end
`else
  assign div_zero = 1'b0;
  assign rsp_err  = 1'b0;
`endif
  // Control FSM: accept, wait out the ALU latency, capture and hold the response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      cnt        <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      alu_s      <= 4'd0;
      alu_en     <= 1'b1;
      rsp_y      <= 16'd0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          id         <= grant1;
          last_grant <= grant1;
          cnt        <= 4'(ALU_LAT);
          if (div_zero) begin
            state      <= RESP;
            rsp_y      <= 16'hFFFF;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp0_valid <= !grant1;
            rsp1_valid <= grant1;
          end else begin
            state <= EXEC;
            alu_a <= a;
            alu_b <= b;
            alu_s <= op;
          end
        end
        EXEC: if (cnt == 4'd0) begin
          state      <= RESP;
          rsp_y      <= alu_y;
          rsp_carry  <= alu_carry;
          rsp_zero   <= alu_y == 16'd0;
          rsp0_valid <= !id;
          rsp1_valid <= id;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_done) begin
          state      <= IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, reset abort and divide-by-zero.
module tb_alu_arbiter;
  localparam int ALU_LAT = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp_y;
  logic        rsp_carry, rsp_zero, rsp_err;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_s;
  logic        alu_en;
  logic [15:0] alu_y;
  logic        alu_carry;
  logic        busy;
  logic [16:0] y1, y2;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_en(alu_en),
    .alu_y(alu_y), .alu_carry(alu_carry), .busy(busy)
  );
  // Reference ALU: {carry, y}; 0 add, 5 divide (0 on b==0), 6 and, 7 xor, 8 or
  function automatic logic [16:0] alu_f(input logic [3:0] s, input logic [7:0] x, input logic [7:0] z);
    logic [8:0] sum;
    sum = {1'b0, x} + {1'b0, z};
    case (s)
      4'd0:    alu_f = {sum[8], 8'h00, sum[7:0]};
      4'd5:    alu_f = (z == 8'd0) ? 17'd0 : {9'd0, x / z};
      4'd6:    alu_f = {9'd0, x & z};
      4'd7:    alu_f = {9'd0, x ^ z};
      4'd8:    alu_f = {9'd0, x | z};
      default: alu_f = 17'd0;
    endcase
  endfunction
  // Two-stage registered ALU so the result is valid ALU_LAT edges after operands change
  always @(posedge clk) begin
    y1 <= alu_f(alu_s, alu_a, alu_b);
    y2 <= y1;
  end
  assign alu_y     = y2[15:0];
  assign alu_carry = y2[16];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a negedge with requests driven: checks grant, latency, response and return to IDLE
  task automatic serve(input string tag, input bit cid, input logic [15:0] ey, input bit ec, input bit ee, input int elat);
    int n;
    #1;
    check({tag, " ready"}, {30'd0, req1_ready, req0_ready}, cid ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!(rsp0_valid || rsp1_valid) && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " lat"}, n, elat);
    check({tag, " valid"}, {30'd0, rsp1_valid, rsp0_valid}, cid ? 32'd2 : 32'd1);
    check({tag, " y"}, {16'd0, rsp_y}, {16'd0, ey});
    check({tag, " carry"}, {31'd0, rsp_carry}, {31'd0, ec});
    check({tag, " zero"}, {31'd0, rsp_zero}, (ey == 16'd0) ? 32'd1 : 32'd0);
    check({tag, " err"}, {31'd0, rsp_err}, {31'd0, ee});
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle"}, {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
  endtask
  initial begin
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst rsp valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst rsp", {rsp_carry, rsp_zero, rsp_err, 13'd0, rsp_y}, 32'd0);
    check("rst alu", {12'd0, alu_s, alu_a, alu_b}, 32'd0);
    check("rst alu_en", {31'd0, alu_en}, 32'd1);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    check("alu_en release", {31'd0, alu_en}, 32'd0);
    // tie after reset, then alternation with both held
    req0_valid = 1; req0_op = 4'd6; req0_a = 8'hF0; req0_b = 8'h0F;
    req1_valid = 1; req1_op = 4'd8; req1_a = 8'hAA; req1_b = 8'h55;
    serve("tie0", 0, 16'h0000, 0, 0, 3);
    serve("tie1", 1, 16'h00FF, 0, 0, 3);
    serve("alt0", 0, 16'h0000, 0, 0, 3);
    serve("alt1", 1, 16'h00FF, 0, 0, 3);
    req0_valid = 0; req1_valid = 0;
    // single add
    req0_valid = 1; req0_op = 4'd0; req0_a = 8'h0F; req0_b = 8'h01;
    serve("add", 0, 16'h0010, 0, 0, 3);
    req0_valid = 0;
    // backpressure on client 1 while client 0 waits
    req1_valid = 1; req1_op = 4'd7; req1_a = 8'h12; req1_b = 8'h21;
    rsp1_ready = 0;
    #1;
    check("bp ready", {30'd0, req1_ready, req0_ready}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_op = 4'd0; req0_a = 8'h01; req0_b = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp hold", {12'd0, busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_y[10:0]},
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'h033});
      check("bp y", {16'd0, rsp_y}, 32'h0033);
      @(posedge clk);
      @(negedge clk);
    end
    rsp1_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp release", {30'd0, busy, rsp1_valid}, 32'd0);
    serve("bp next", 0, 16'h0003, 0, 0, 3);
    req0_valid = 0;
    // reset one cycle after accepting a req0 op
    req0_valid = 1; req0_op = 4'd0; req0_a = 8'h11; req0_b = 8'h22;
    #1;
    check("abort ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check("abort alu_en", {31'd0, alu_en}, 32'd1);
    check("abort state", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
    check("abort rsp_y", {16'd0, rsp_y}, 32'd0);
    check("abort alu", {12'd0, alu_s, alu_a, alu_b}, 32'd0);
    rst_n = 1;
    req0_valid = 1; req0_op = 4'd6; req0_a = 8'hF0; req0_b = 8'h0F;
    req1_valid = 1; req1_op = 4'd8; req1_a = 8'hAA; req1_b = 8'h55;
    serve("post rst0", 0, 16'h0000, 0, 0, 3);
    serve("post rst1", 1, 16'h00FF, 0, 0, 3);
    req0_valid = 0; req1_valid = 0;
    // divide by zero
    req0_valid = 1; req0_op = 4'd5; req0_a = 8'h09; req0_b = 8'h00;
`ifdef ALU_ARB_DIVZERO_EN
    serve("div0", 0, 16'hFFFF, 0, 1, 0);
    check("div0 alu_s", {28'd0, alu_s}, 32'd8);
`else
    serve("div0", 0, 16'h0000, 0, 0, 3);
    check("div0 alu_s", {28'd0, alu_s}, 32'd5);
`endif
    req0_valid = 0;
    // req1 raised during a req0 op must win the next IDLE
    req0_valid = 1; req0_op = 4'd0; req0_a = 8'hFF; req0_b = 8'h02;
    fork
      serve("starve0", 0, 16'h0001, 1, 0, 3);
      begin
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1; req1_op = 4'd7; req1_a = 8'h0F; req1_b = 8'hF0;
        req0_op = 4'd0; req0_a = 8'h03; req0_b = 8'h04;
        #1;
        check("starve mid ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
    join
    serve("starve1", 1, 16'h00FF, 0, 0, 3);
    req1_valid = 0;
    serve("starve2", 0, 16'h0007, 0, 0, 3);
    req0_valid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
